// File: rtl/fine_code_encoder.sv
// Converts captured Start/Stop thermometer codes from the fine delay line into tap counts.
// Optional single-bubble majority filter is enabled with `FINE_BUBBLE_FILTER_EN.
module fine_code_encoder #(
  parameter int NUM = 12,
  parameter int W   = 4
) (
  input  logic           clk,
  input  logic           iRst,
  input  logic [NUM-1:0] iFFStart,
  input  logic [NUM-1:0] iFFStop,
  input  logic           iStartCaptured,
  input  logic           iStopCaptured,
  input  logic           iReady,
  output logic           oValid,
  output logic [W-1:0]   oFineStart,
  output logic [W-1:0]   oFineStop,
  output logic [1:0]     oErr,
  output logic           oBusy
);

  localparam int NIB = NUM / 4;

  typedef enum logic [2:0] {IDLE, ARMED, SAMPLE, SUM1, SUM2, DONE} state_t;

  state_t state, state_next;

  logic [NUM-1:0] start_filt, stop_filt;
  logic [NUM-1:0] start_code, stop_code;
  logic [2:0]     start_nib [NIB];
  logic [2:0]     stop_nib  [NIB];
  logic           start_bad, stop_bad;
  logic [W-1:0]   start_sum, stop_sum;
  logic           start_bad_next, stop_bad_next;

  function automatic logic [2:0] pop4(input logic [3:0] n);
    return 3'(n[0]) + 3'(n[1]) + 3'(n[2]) + 3'(n[3]);
  endfunction

`ifdef FINE_BUBBLE_FILTER_EN
  logic [NUM+1:0] start_ext, stop_ext;

  // Virtual taps below the chain read 1 and above read 0, so edge taps keep their value.
  always_comb begin
    start_ext  = {1'b0, iFFStart, 1'b1};
    stop_ext   = {1'b0, iFFStop, 1'b1};
    start_filt = '0;
    stop_filt  = '0;
    for (int i = 0; i < NUM; i++) begin
      start_filt[i] = (start_ext[i] & start_ext[i+1]) | (start_ext[i] & start_ext[i+2]) |
                      (start_ext[i+1] & start_ext[i+2]);
      stop_filt[i]  = (stop_ext[i] & stop_ext[i+1]) | (stop_ext[i] & stop_ext[i+2]) |
                      (stop_ext[i+1] & stop_ext[i+2]);
    end
  end
`else
  assign start_filt = iFFStart;
  assign stop_filt  = iFFStop;
`endif

  always_ff @(posedge clk) begin
    if (iRst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (iStartCaptured && iStopCaptured) state_next = SAMPLE;
        else if (iStartCaptured)             state_next = ARMED;
      end
      ARMED:   if (iStopCaptured) state_next = SAMPLE;
      SAMPLE:  state_next = SUM1;
      SUM1:    state_next = SUM2;
      SUM2:    state_next = DONE;
      DONE:    if (iReady) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    oValid = 1'b0;
    oBusy  = 1'b0;
    case (state)
      IDLE, ARMED: oBusy = 1'b0;
      DONE: begin
        oValid = 1'b1;
        oBusy  = 1'b1;
      end
      default: oBusy = 1'b1;
    endcase
  end

  // A pure thermometer code plus one is a power of two, so it shares no set bit with itself.
  always_comb begin
    start_bad_next = |(start_code & (start_code + NUM'(1)));
    stop_bad_next  = |(stop_code & (stop_code + NUM'(1)));
    start_sum      = '0;
    stop_sum       = '0;
    for (int k = 0; k < NIB; k++) begin
      start_sum = start_sum + W'(start_nib[k]);
      stop_sum  = stop_sum + W'(stop_nib[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (iRst) begin
      start_code <= '0;
      stop_code  <= '0;
      start_bad  <= 1'b0;
      stop_bad   <= 1'b0;
      oFineStart <= '0;
      oFineStop  <= '0;
      oErr       <= '0;
      for (int k = 0; k < NIB; k++) begin
        start_nib[k] <= '0;
        stop_nib[k]  <= '0;
      end
    end else begin
      case (state)
        SAMPLE: begin
          start_code <= start_filt;
          stop_code  <= stop_filt;
        end
        SUM1: begin
          for (int k = 0; k < NIB; k++) begin
            start_nib[k] <= pop4(start_code[4*k +: 4]);
            stop_nib[k]  <= pop4(stop_code[4*k +: 4]);
          end
          start_bad <= start_bad_next;
          stop_bad  <= stop_bad_next;
        end
        SUM2: begin
          oFineStart <= start_sum;
          oFineStop  <= stop_sum;
          oErr       <= {stop_bad, start_bad};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fine_code_encoder.md
# fine_code_encoder

Downstream consumer of the fine delay-line stage: takes the NUM-bit Start and Stop flip-flop column codes after each column is captured and converts each thermometer code to a binary tap count. Sequences one measurement at a time (start, then stop), flags non-thermometer codes, and hands the start/stop fine values to the timestamp/arbiter logic through a valid/ready handshake.

## Interface
- NUM, 12, number of delay-chain taps per column; multiple of 4.
- W, 4, output count width; must satisfy 2^W > NUM.

- clk  in  1  single clock, same domain as the fine FF columns.
- iRst  in  1  reset, synchronous, active-high.
- iFFStart  in  NUM  Start column code; bit 0 is the first tap.
- iFFStop  in  NUM  Stop column code.
- iStartCaptured  in  1  one-cycle pulse, coincident with the Start column enable; column value is valid from the next cycle.
- iStopCaptured  in  1  one-cycle pulse, coincident with the Stop column enable; column value is valid from the next cycle.
- iReady  in  1  consumer accepts the result when oValid && iReady.
- oValid  out  1  result valid; held until accepted.
- oFineStart  out  W  ones-count of the sampled Start code, 0..NUM.
- oFineStop  out  W  ones-count of the sampled Stop code, 0..NUM.
- oErr  out  2  bit0: Start code not a pure thermometer; bit1: same for Stop.
- oBusy  out  1  high in every state except IDLE and ARMED.

## Operation
- FSM states: IDLE, ARMED, SAMPLE, SUM1, SUM2, DONE.
- IDLE: iStartCaptured -> ARMED; iStartCaptured && iStopCaptured together -> SAMPLE; iStopCaptured alone is ignored.
- ARMED: iStopCaptured -> SAMPLE; a repeated iStartCaptured stays in ARMED (the newer Start capture wins).
- SAMPLE (1 cycle): register iFFStart and iFFStop (after the optional filter) into code registers; -> SUM1.
- SUM1: register per-nibble popcounts, NUM/4 values of 3 bits each per code, plus the thermometer check; -> SUM2.
- SUM2: register the nibble-sum totals into oFineStart and oFineStop, and set oErr; -> DONE.
- DONE: oValid=1. On iReady -> IDLE, with oValid low from the next cycle. Outputs hold their values until the next SUM2.
- Capture pulses in SAMPLE, SUM1, SUM2 and DONE are dropped (no queuing).
- Thermometer check: a code is invalid if any bit i=1 while some bit j<i is 0. The count is still reported as the raw popcount.
- Arithmetic: unsigned sum, zero-extended to W; an all-ones code gives NUM and never wraps.
- Reset (any state, including mid-operation): next state IDLE; oValid=0, oFineStart=0, oFineStop=0, oErr=0, oBusy=0, code registers=0.

## Timing
- Stop pulse in cycle n -> SAMPLE in n+1 -> SUM1 in n+2 -> SUM2 in n+3 -> oValid=1 in n+4.
- Minimum stop-to-valid latency is 4 cycles. With iReady held high, the minimum restart interval is 5 cycles; the block accepts the next Start pulse in cycle n+5 (IDLE).
- iReady is sampled only in DONE; iReady high in other states has no effect.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro: `FINE_BUBBLE_FILTER_EN`.
- Defined: each tap is replaced by majority(t[i-1], t[i], t[i+1]) before the SAMPLE register, with t[-1]=1 and t[NUM]=0. Single-bit bubbles are removed, and oErr reflects the filtered code. Latency is unchanged.
- Undefined: raw codes are registered.

## Test plan
- Basic (NUM=12): Start pulse; iFFStart=12'h01F. Stop pulse; iFFStop=12'h3FF; iReady=1 -> oValid in cycle n+4, oFineStart=5, oFineStop=10, oErr=0, one-cycle oValid.
- Backpressure: as above with iReady=0 for 6 cycles -> oValid and outputs stable for 6 cycles. New capture pulses during this window are ignored. Raise iReady -> IDLE next cycle.
- Simultaneous Start and Stop pulses in IDLE, iFFStart=12'h000, iFFStop=12'hFFF -> oFineStart=0, oFineStop=12 (no wrap), oValid at n+4.
- Bubble: iFFStop=12'h0FB. Filter undefined -> oFineStop=7, oErr=2'b10. Filter defined -> oFineStop=8, oErr=2'b00.
- Orphan and re-arm: Stop pulse in IDLE -> no state change. Two Start pulses, then Stop -> oFineStart reflects the iFFStart value present after the Stop pulse.
- Reset in SUM1 -> next cycle IDLE, all outputs 0. Stop pulse without a prior Start -> no oValid.
